// File: rtl/zap_postalu_pipe_slice.sv
// Post-ALU elastic slice: DEPTH-entry buffer, 1-cycle latency, full throughput while not full.
// o_ready depends only on state and occupancy; a full slice refuses a push even when it pops that cycle.
// Optional ZAP_PIPE_SLICE_OCC_EN exposes the occupancy counter as o_count.
module zap_postalu_pipe_slice #(
    parameter int DATA_WDT = 32,
    parameter int CTRL_WDT = 16,
    parameter int DEPTH    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear_from_writeback,
    input  logic                    i_data_mem_fault,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WDT-1:0]     i_data,
    input  logic [CTRL_WDT-1:0]     i_ctrl,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WDT-1:0]     o_data,
    output logic [CTRL_WDT-1:0]     o_ctrl,
    output logic                    o_sleep
`ifdef ZAP_PIPE_SLICE_OCC_EN
    ,
    output logic [$clog2(DEPTH):0]  o_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_SLEEP = 1'b1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WDT-1:0] mem_data [DEPTH];
    logic [CTRL_WDT-1:0] mem_ctrl [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [0:0]       state;

    logic push;
    logic pop;
    logic store;
    logic flush;

    assign flush = i_clear_from_writeback;
    assign push  = i_valid & o_ready;
    assign pop   = o_valid & i_ready;
    // A faulting beat is consumed by the handshake but never written: it becomes a bubble.
    assign store = push & ~i_data_mem_fault;

    assign o_ready = (state == ST_RUN) && (count != CNT_FULL);
    assign o_valid = (count != '0);
    assign o_sleep = (state == ST_SLEEP);
    assign o_data  = mem_data[rd_ptr];
    assign o_ctrl  = o_valid ? mem_ctrl[rd_ptr] : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_RUN;
        end else if (flush) begin
            state <= ST_RUN;
        end else if (push && i_data_mem_fault) begin
            state <= ST_SLEEP;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not cleared on flush; the zeroed count hides stale entries.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_ctrl[i] <= '0;
            end
        end else if (store && !flush) begin
            mem_data[wr_ptr] <= i_data;
            mem_ctrl[wr_ptr] <= i_ctrl;
        end
    end

`ifdef ZAP_PIPE_SLICE_OCC_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (store && !pop) begin
            count_q <= count_q + 1'b1;
        end else if (pop && !store) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count   = count_q;
    assign o_count = count_q;
`else
    // Wrap bits extend the pointers so full and empty stay distinguishable.
    logic wr_wrap;
    logic rd_wrap;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else if (flush) begin
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else begin
            if (store && (wr_ptr == PTR_LAST)) begin
                wr_wrap <= ~wr_wrap;
            end
            if (pop && (rd_ptr == PTR_LAST)) begin
                rd_wrap <= ~rd_wrap;
            end
        end
    end

    assign count = {wr_wrap, wr_ptr} - {rd_wrap, rd_ptr};
`endif

endmodule

// File: tb/tb_zap_postalu_pipe_slice.sv
// Directed bench for zap_postalu_pipe_slice at DEPTH=2: handshake, backpressure, sleep, flush, wrap, async reset.
module tb_zap_postalu_pipe_slice;

    logic        i_clk;
    logic        i_reset;
    logic        i_clear_from_writeback;
    logic        i_data_mem_fault;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [15:0] i_ctrl;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [15:0] o_ctrl;
    logic        o_sleep;
`ifdef ZAP_PIPE_SLICE_OCC_EN
    logic [1:0]  o_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    zap_postalu_pipe_slice #(.DATA_WDT(32), .CTRL_WDT(16), .DEPTH(2)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_mem_fault       (i_data_mem_fault),
        .i_valid                (i_valid),
        .o_ready                (o_ready),
        .i_data                 (i_data),
        .i_ctrl                 (i_ctrl),
        .o_valid                (o_valid),
        .i_ready                (i_ready),
        .o_data                 (o_data),
        .o_ctrl                 (o_ctrl),
        .o_sleep                (o_sleep)
`ifdef ZAP_PIPE_SLICE_OCC_EN
        ,
        .o_count                (o_count)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c,
                         input logic r, input logic f, input logic clr);
        i_valid                = v;
        i_data                 = d;
        i_ctrl                 = c;
        i_ready                = r;
        i_data_mem_fault       = f;
        i_clear_from_writeback = clr;
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;

        i_reset = 1'b1;
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_data",  o_data, 0);
        check_eq("rst_ctrl",  o_ctrl, 0);
        check_eq("rst_sleep", o_sleep, 0);
`ifdef ZAP_PIPE_SLICE_OCC_EN
        check_eq("rst_count", o_count, 0);
`endif
        i_reset = 1'b0;
        tick();
        check_eq("rst_ready", o_ready, 1);

        // 1: single beat, 1-cycle latency
        drive(1'b1, 32'hA5A5_0001, 16'h0003, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t1_valid", o_valid, 1);
        check_eq("t1_data",  o_data, 32'hA5A5_0001);
        check_eq("t1_ctrl",  o_ctrl, 16'h0003);
        tick();
        check_eq("t1_valid_after", o_valid, 0);
        check_eq("t1_ctrl_after",  o_ctrl, 0);

        // Fault without a push must not sleep
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b0);
        tick();
        check_eq("fault_nopush_sleep", o_sleep, 0);

        // 2: backpressure, full refuses the third beat
        drive(1'b1, 32'h0000_0011, 16'h0101, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("t2_ready_after1", o_ready, 1);
        drive(1'b1, 32'h0000_0022, 16'h0202, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("t2_ready_full", o_ready, 0);
        check_eq("t2_head1", o_data, 32'h0000_0011);
        drive(1'b1, 32'h0000_0033, 16'h0303, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("t2_full_fault_sleep", o_sleep, 0);
        check_eq("t2_still_full", o_ready, 0);
        drive(1'b1, 32'h0000_0033, 16'h0303, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("t2_head2", o_data, 32'h0000_0022);
        check_eq("t2_ctrl2", o_ctrl, 16'h0202);
        check_eq("t2_ready_notfull", o_ready, 1);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_head3", o_data, 32'h0000_0033);
        check_eq("t2_valid3", o_valid, 1);
        tick();
        check_eq("t2_empty", o_valid, 0);

        // 3: faulting beat becomes a bubble and puts the slice to sleep
        drive(1'b1, 32'h0000_00AA, 16'h00AA, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_00BB, 16'h00BB, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("t3_sleep", o_sleep, 1);
        check_eq("t3_ready", o_ready, 0);
        check_eq("t3_head_x", o_data, 32'h0000_00AA);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("t3_y_absent", o_valid, 0);
        check_eq("t3_still_sleep", o_sleep, 1);
        drive(1'b1, 32'h0000_00CC, 16'h00CC, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("t3_sleep_ignores_valid", o_valid, 0);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_wake_sleep", o_sleep, 0);
        check_eq("t3_wake_ready", o_ready, 1);

        // 4: flush of a full slice dominates push and pop
        drive(1'b1, 32'h0000_0041, 16'h0041, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0042, 16'h0042, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("t4_full", o_ready, 0);
        drive(1'b1, 32'h0000_0043, 16'h0043, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t4_valid", o_valid, 0);
        check_eq("t4_ctrl", o_ctrl, 0);
        check_eq("t4_ready", o_ready, 1);
`ifdef ZAP_PIPE_SLICE_OCC_EN
        check_eq("t4_count", o_count, 0);
`endif
        // Flush together with an accepted push into a partly filled slice
        drive(1'b1, 32'h0000_0051, 16'h0051, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0052, 16'h0052, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t4_push_flush_valid", o_valid, 0);
        check_eq("t4_push_flush_sleep", o_sleep, 0);
        tick();
        check_eq("t4_beat_dropped", o_valid, 0);

        // 5: stream across pointer wrap with random backpressure
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 7 && cyc < 300) begin
            i_ready          = 1'($urandom_range(0, 1));
            i_valid          = (sent < 7);
            i_data           = 32'h0000_1000 + 32'(sent);
            i_ctrl           = 16'h0010 + 16'(sent);
            i_data_mem_fault = 1'b0;
            if (o_valid && i_ready) begin
                check_eq("t5_data", o_data, 32'h0000_1000 + 32'(recv));
                check_eq("t5_ctrl", o_ctrl, 32'h0000_0010 + 32'(recv));
                recv++;
            end
            if (i_valid && o_ready) sent++;
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        check_eq("t5_received", 32'(recv), 7);
        i_ready = 1'b1;
        tick();
        check_eq("t5_no_dup", o_valid, 0);

        // 6: asynchronous reset between clock edges
        drive(1'b1, 32'h0000_0061, 16'h0061, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0062, 16'h0062, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_pre_valid", o_valid, 1);
        #1;
        i_reset = 1'b1;
        #1;
        check_eq("t6_async_valid", o_valid, 0);
        check_eq("t6_async_ctrl", o_ctrl, 0);
        check_eq("t6_async_data", o_data, 0);
        check_eq("t6_async_ready", o_ready, 1);
`ifdef ZAP_PIPE_SLICE_OCC_EN
        check_eq("t6_async_count", o_count, 0);
`endif
        #1;
        i_reset = 1'b0;
        i_ready = 1'b1;
        tick();
        check_eq("t6_no_survivor", o_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
